// File: rtl/miner_pkg.sv
// Shared definitions for the golden-nonce reporting path.
package miner_pkg;

  localparam int NONCE_W   = 32;
  localparam int MAX_CORES = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or after ptr, wrapping modulo N.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + k) % N]   = 1'b1;
        idx                          = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/nonce_tx_scheduler.sv
// Per-core one-deep nonce slots, round-robin granted onto the single serial TX port.
// tx_ready 1 cycle after pending is visible; stalls while tx_busy, retries after BUSY_TIMEOUT.
module nonce_tx_scheduler
  import miner_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CORES-1:0]           nonce_valid,
  input  logic [NONCE_W*NUM_CORES-1:0]   nonce_in,
  input  logic                           new_work,
  output logic                           tx_ready,
  output logic [NONCE_W-1:0]             word,
  input  logic                           tx_busy,
  output logic [NUM_CORES-1:0]           pending,
  output logic [7:0]                     drop_count
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t              state;
  logic [NONCE_W-1:0]     slot [NUM_CORES];
  logic [PW-1:0]          rr_ptr, gnt_idx, arb_idx, ptr_nxt;
  logic [NUM_CORES-1:0]   arb_oh, granted_oh, pend_nxt;
  logic                   arb_any, grant_fire, timeout, restore;
  logic [TW-1:0]          wait_cnt;
  logic [4:0]             drop_add;
  logic [8:0]             drop_sum;

  rr_arbiter #(.N(NUM_CORES), .IW(PW)) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (arb_oh),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign grant_fire = (state == IDLE) && arb_any && !tx_busy;
  assign granted_oh = grant_fire ? arb_oh : '0;
  assign ptr_nxt    = (arb_idx == PW'(NUM_CORES - 1)) ? '0 : arb_idx + 1'b1;
  assign timeout    = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == TW'(BUSY_TIMEOUT - 1));
  // An abandoned grant is put back only if its slot was not refilled meanwhile.
  assign restore    = timeout && !(pending[gnt_idx] || nonce_valid[gnt_idx]);
  assign drop_sum   = {1'b0, drop_count} + 9'(drop_add);

  always_comb begin
    pend_nxt = pending;
    drop_add = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (granted_oh[i]) begin
        pend_nxt[i] = 1'b0;
      end else if (pending[i] && (nonce_valid[i] || new_work)) begin
        pend_nxt[i] = 1'b0;
        drop_add    = drop_add + 5'd1;
      end
      if (nonce_valid[i]) pend_nxt[i] = 1'b1;
    end
    if (timeout) begin
      if (restore) pend_nxt[gnt_idx] = 1'b1;
      else         drop_add = drop_add + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx_ready   <= 1'b0;
      word       <= '0;
      pending    <= '0;
      drop_count <= '0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      wait_cnt   <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot[i] <= '0;
    end else begin
      tx_ready   <= 1'b0;
      pending    <= pend_nxt;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int i = 0; i < NUM_CORES; i++) begin
        if (nonce_valid[i]) slot[i] <= nonce_in[NONCE_W*i +: NONCE_W];
      end
      if (restore) slot[gnt_idx] <= word;
      case (state)
        IDLE: begin
          if (grant_fire) begin
            tx_ready <= 1'b1;
            word     <= slot[arb_idx];
            gnt_idx  <= arb_idx;
            rr_ptr   <= ptr_nxt;
            wait_cnt <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy)      state    <= WAIT_DONE;
          else if (timeout) state    <= IDLE;
          else              wait_cnt <= wait_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// Directed bench for nonce_tx_scheduler with a serial_core stand-in and a reference model.
module tb_nonce_tx_scheduler;

  localparam int NC = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   nonce_valid;
  logic [32*NC-1:0] nonce_in;
  logic            new_work;
  logic            tx_ready;
  logic [31:0]     word;
  logic            tx_busy;
  logic [NC-1:0]   pending;
  logic [7:0]      drop_count;

  nonce_tx_scheduler #(.NUM_CORES(NC), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .new_work(new_work), .tx_ready(tx_ready), .word(word), .tx_busy(tx_busy),
    .pending(pending), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // serial_core stand-in: busy rises the cycle after tx_ready and stays high 40 cycles
  logic srv_en = 1'b1;
  logic start_next = 1'b0;
  int   busy_left = 0;
  initial tx_busy = 1'b0;
  always @(negedge clk) begin
    if (start_next) begin
      tx_busy    = 1'b1;
      busy_left  = 40;
      start_next = 1'b0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (tx_ready === 1'b1 && srv_en) start_next = 1'b1;
  end

  // record every transmitted word and the cycle it was offered
  logic [31:0] sent[$];
  int          sent_t[$];
  always @(negedge clk) begin
    if (tx_ready === 1'b1) begin
      sent.push_back(word);
      sent_t.push_back(cyc);
    end
  end

  // Reference model: one slot per core, a round-robin search, and a link that is
  // free, awaiting busy (with an age), or busy.
  logic [31:0]   m_slot [NC];
  logic [NC-1:0] m_pend;
  logic [NC-1:0] p0;
  logic          m_txr;
  logic [31:0]   m_word;
  int m_ptr, m_link, m_age, m_gidx, m_drops, lk0, g, add;
  logic m_on = 1'b0;
  logic tout;

  task model_step();
    if (reset) begin
      m_on = 1'b1; m_pend = '0; m_txr = 1'b0; m_word = '0;
      m_ptr = 0; m_link = 0; m_age = 0; m_gidx = 0; m_drops = 0;
      for (int i = 0; i < NC; i++) m_slot[i] = '0;
    end else if (m_on) begin
      p0 = m_pend; lk0 = m_link; g = -1; add = 0; tout = 1'b0;
      if (lk0 == 0 && p0 != 0 && !tx_busy)
        for (int k = 0; k < NC; k++)
          if (g < 0 && p0[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
      m_txr = (g >= 0);
      if (g >= 0) begin
        m_word = m_slot[g]; m_gidx = g; m_ptr = (g + 1) % NC; m_link = 1; m_age = 0;
      end else if (lk0 == 1) begin
        if (tx_busy) m_link = 2;
        else if (m_age == TO - 1) begin m_link = 0; tout = 1'b1; end
        else m_age = m_age + 1;
      end else if (lk0 == 2 && !tx_busy) m_link = 0;
      for (int i = 0; i < NC; i++) begin
        if (i == g) m_pend[i] = 1'b0;
        else if (p0[i] && (nonce_valid[i] || new_work)) begin m_pend[i] = 1'b0; add++; end
        if (nonce_valid[i]) begin m_pend[i] = 1'b1; m_slot[i] = nonce_in[32*i +: 32]; end
      end
      if (tout) begin
        if (p0[m_gidx] || nonce_valid[m_gidx]) add++;
        else begin m_pend[m_gidx] = 1'b1; m_slot[m_gidx] = m_word; end
      end
      m_drops = (m_drops + add > 255) ? 255 : m_drops + add;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_on) begin
      check("model tx_ready", {31'd0, tx_ready}, {31'd0, m_txr});
      check("model word", word, m_word);
      check("model pending", {28'd0, pending}, {28'd0, m_pend});
      check("model drop_count", {24'd0, drop_count}, m_drops[31:0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [NC-1:0] mask, input logic [32*NC-1:0] vals);
    @(negedge clk);
    nonce_valid = mask;
    nonce_in    = vals;
    @(negedge clk);
    nonce_valid = '0;
  endtask

  task automatic wait_txr(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) seen = 1'b1;
    end
    check({name, " tx_ready seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int idle;
    idle = 0;
    for (int k = 0; k < 1500 && idle < 3; k++) begin
      @(negedge clk);
      if (tx_ready === 1'b0 && !tx_busy && pending == '0 && !start_next) idle++;
      else idle = 0;
    end
    check({name, " settled"}, idle, 32'd3);
  endtask

  task automatic check_order(input string name, input int s, input logic [31:0] e0,
                             input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({name, " count"}, sent.size() - s, 32'd4);
    for (int i = 0; i < 4; i++)
      check(name, (s + i < sent.size()) ? sent[s + i] : 32'hDEAD_DEAD, e[i]);
  endtask

  int s0;

  initial begin
    reset = 1'b1; nonce_valid = '0; nonce_in = '0; new_work = 1'b0;
    tick(3);
    check("reset tx_ready", {31'd0, tx_ready}, 32'd0);
    check("reset word", word, 32'd0);
    check("reset pending", {28'd0, pending}, 32'd0);
    check("reset drop_count", {24'd0, drop_count}, 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: single report from core 2
    strobe(4'b0100, {32'd0, 32'h0000318F, 64'd0});
    check("t1 pending", {28'd0, pending}, 32'h4);
    tick(1);
    check("t1 tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t1 word", word, 32'h0000318F);
    check("t1 pending cleared", {28'd0, pending}, 32'd0);
    wait_quiet("t1");

    // 2: fairness; core3 first so the pointer starts at 0
    strobe(4'b1000, {32'h33, 96'd0});
    wait_quiet("t2 prep");
    s0 = sent.size();
    strobe(4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    wait_quiet("t2a");
    check_order("t2a order", s0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    strobe(4'b0010, {64'd0, 32'h11, 32'd0});
    wait_quiet("t2 ptr2");
    s0 = sent.size();
    strobe(4'b1111, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    wait_quiet("t2b");
    check_order("t2b order", s0, 32'hB2, 32'hB3, 32'hB0, 32'hB1);

    // 3: overwrite while core 0 transmits
    s0 = sent.size();
    strobe(4'b0001, {96'd0, 32'hC0});
    wait_txr("t3");
    tick(3);
    strobe(4'b0010, {64'd0, 32'hAAAA_0001, 32'd0});
    tick(3);
    strobe(4'b0010, {64'd0, 32'hBBBB_0001, 32'd0});
    wait_quiet("t3");
    check("t3 sends", sent.size() - s0, 32'd2);
    check("t3 last word", sent[sent.size() - 1], 32'hBBBB_0001);
    check("t3 drop_count", {24'd0, drop_count}, 32'd1);

    // 4: flush during a transfer
    s0 = sent.size();
    strobe(4'b0001, {96'd0, 32'hD0});
    wait_txr("t4");
    tick(5);
    strobe(4'b1010, {32'hD3, 32'd0, 32'hD1, 32'd0});
    check("t4 pending before flush", {28'd0, pending}, 32'hA);
    new_work = 1'b1;
    tick(1);
    new_work = 1'b0;
    check("t4 pending flushed", {28'd0, pending}, 32'd0);
    check("t4 drop_count", {24'd0, drop_count}, 32'd3);
    wait_quiet("t4");
    check("t4 sends", sent.size() - s0, 32'd1);
    check("t4 word", sent[sent.size() - 1], 32'hD0);

    // 5: timeout and retry
    srv_en = 1'b0;
    s0 = sent.size();
    strobe(4'b0100, {32'd0, 32'hE2, 64'd0});
    wait_txr("t5 first");
    tick(63);
    check("t5 pending still clear", {28'd0, pending}, 32'd0);
    tick(1);
    check("t5 pending restored", {28'd0, pending}, 32'h4);
    srv_en = 1'b1;
    wait_txr("t5 retry");
    check("t5 retry word", word, 32'hE2);
    wait_quiet("t5");
    check("t5 sends", sent.size() - s0, 32'd2);
    check("t5 retry gap", (sent.size() >= 2) ? sent_t[sent.size() - 1] - sent_t[sent.size() - 2] : 0, 32'd65);
    check("t5 drop_count", {24'd0, drop_count}, 32'd3);

    // 6: reset in WAIT_DONE, then a normal report
    strobe(4'b0010, {64'd0, 32'hF1, 32'd0});
    wait_txr("t6");
    tick(5);
    reset = 1'b1;
    tick(1);
    check("t6 tx_ready", {31'd0, tx_ready}, 32'd0);
    check("t6 word", word, 32'd0);
    check("t6 pending", {28'd0, pending}, 32'd0);
    check("t6 drop_count", {24'd0, drop_count}, 32'd0);
    reset = 1'b0;
    s0 = sent.size();
    strobe(4'b0001, {96'd0, 32'h600D});
    wait_quiet("t6 after reset");
    check("t6 sends", sent.size() - s0, 32'd1);
    check("t6 word sent", sent[sent.size() - 1], 32'h600D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
